// File: rtl/data_memory.sv
// Word-addressed data memory for the MEM stage.
// Synchronous write and reset, combinational gated read.
module data_memory #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wd,
  input  logic              writememo,
  input  logic              readmemo,
  output logic [DATA_W-1:0] rd
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Reset wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (writememo) begin
      mem[addr] <= wd;
    end
  end

  assign rd = readmemo ? mem[addr] : '0;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory.
// Directed steps followed by random traffic against an array model.
module tb_data_memory;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wd = '0;
  logic        writememo = 1'b0;
  logic        readmemo = 1'b0;
  logic [31:0] rd;

  logic [31:0] model [32];
  int compared = 0;
  int mismatched = 0;

  data_memory dut (
    .clk(clk),
    .rst(rst),
    .addr(addr),
    .wd(wd),
    .writememo(writememo),
    .readmemo(readmemo),
    .rd(rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] exp);
    compared++;
    assert (rd === exp) else begin
      mismatched++;
      $error("FAIL %s rd=%h expected=%h", tag, rd, exp);
    end
  endtask

  // One clock edge with the given controls; model follows the rules.
  task automatic step(input logic r, input logic we,
                      input logic [4:0] a, input logic [31:0] d);
    rst = r;
    writememo = we;
    addr = a;
    wd = d;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
    end else if (we) begin
      model[a] = d;
    end
    #1;
    rst = 1'b0;
    writememo = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [4:0] a,
                       input logic [31:0] exp);
    readmemo = 1'b1;
    addr = a;
    #1;
    chk(tag, exp);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;
    @(negedge clk);

    // Reset clear
    step(1'b1, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 32; i++) rdchk("reset_clear", 5'(i), 32'd0);

    // Basic writes
    readmemo = 1'b0;
    step(1'b0, 1'b1, 5'd0, 32'd36);
    step(1'b0, 1'b1, 5'd1, 32'd60);
    step(1'b0, 1'b1, 5'd2, -32'sd4);
    rdchk("wr_addr0", 5'd0, 32'd36);
    rdchk("wr_addr1", 5'd1, 32'd60);
    rdchk("wr_addr2_neg", 5'd2, 32'hFFFF_FFFC);
    for (int i = 4; i <= 8; i++) rdchk("wr_untouched", 5'(i), 32'd0);

    // Read gating, no clock edge between the two checks
    readmemo = 1'b0;
    addr = 5'd1;
    #1;
    chk("read_gated_off", 32'd0);
    readmemo = 1'b1;
    #1;
    chk("read_gated_on", 32'd60);

    // Write-enable gating
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 5'd3, 32'hDEAD_BEEF);
    rdchk("we_gated", 5'd3, 32'd0);

    // Reset priority over write, clears earlier data
    step(1'b1, 1'b1, 5'd5, 32'd7);
    rdchk("rst_prio_addr5", 5'd5, 32'd0);
    rdchk("rst_clr_addr0", 5'd0, 32'd0);
    rdchk("rst_clr_addr1", 5'd1, 32'd0);
    rdchk("rst_clr_addr2", 5'd2, 32'd0);

    // Boundary addresses
    step(1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF);
    step(1'b0, 1'b1, 5'd0, 32'h1);
    for (int i = 0; i < 32; i++) begin
      rdchk("boundary_sweep", 5'(i),
            (i == 31) ? 32'hFFFF_FFFF : (i == 0) ? 32'h1 : 32'h0);
    end

    // Read during write at addr 31
    readmemo = 1'b1;
    addr = 5'd31;
    writememo = 1'b1;
    wd = 32'h1234_5678;
    #1;
    chk("rdw_before_edge", 32'hFFFF_FFFF);
    @(posedge clk);
    model[31] = 32'h1234_5678;
    #1;
    writememo = 1'b0;
    #1;
    chk("rdw_after_edge", 32'h1234_5678);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic        r;
      logic        we;
      logic [4:0]  a;
      logic [31:0] d;
      r = ($urandom_range(0, 39) == 0);
      we = 1'($urandom);
      a = 5'($urandom);
      d = $urandom;
      readmemo = 1'($urandom);
      rst = r;
      writememo = we;
      addr = a;
      wd = d;
      #1;
      chk("rand_pre_edge", readmemo ? model[a] : 32'd0);
      @(posedge clk);
      if (r) begin
        for (int i = 0; i < 32; i++) model[i] = '0;
      end else if (we) begin
        model[a] = d;
      end
      #1;
      rst = 1'b0;
      writememo = 1'b0;
      a = 5'($urandom);
      rdchk("rand_post_edge", a, model[a]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
